// File: rtl/dsm2_stim_echip65.sv
// Digital 2nd-order delta-sigma stimulus for the CIC3 filter row: one shared bitstream, masked per channel.
// Optional dither (LFSR LSB as +/-1 into the first integrator) is built when DSM2_DITHER_EN is defined.
module dsm2_stim_echip65 #(
    parameter int NUM_CH = 12,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mod_en,
    input  logic [15:0]       x_in,
    input  logic              start,
    input  logic              abort,
    input  logic [CNT_W-1:0]  burst_len,
    input  logic [NUM_CH-1:0] chan_mask,
    output logic [NUM_CH-1:0] out,
    output logic              busy,
    output logic              done
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic signed [21:0] I1_MAX = 22'sd524287;
    localparam logic signed [21:0] I1_MIN = -22'sd524288;
    localparam logic signed [25:0] I2_MAX = 26'sd8388607;
    localparam logic signed [25:0] I2_MIN = -26'sd8388608;

    logic [1:0]        state_q, state_d;
    logic [19:0]       i1_q, i1_d;
    logic [23:0]       i2_q, i2_d;
    logic              bit_q, bit_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              cont_q, cont_d;
    logic [NUM_CH-1:0] out_q, out_d;

    logic signed [21:0] fb1, dith, i1_sum;
    logic signed [25:0] fb2, i2_sum;
    logic [19:0]        i1_sat;
    logic [23:0]        i2_sat;
    logic               out_live;

`ifdef DSM2_DITHER_EN
    logic [15:0] lfsr_q, lfsr_d;
    assign dith = lfsr_q[0] ? 22'sd1 : -22'sd1;
`else
    assign dith = 22'sd0;
`endif

    // Wide sums so the clamp sees the true value before truncation.
    always_comb begin
        fb1    = bit_q ? 22'sd32768 : -22'sd32768;
        fb2    = bit_q ? 26'sd32768 : -26'sd32768;
        i1_sum = $signed({{6{x_in[15]}}, x_in}) + $signed({{2{i1_q[19]}}, i1_q}) - fb1 + dith;
        i2_sum = $signed({{2{i2_q[23]}}, i2_q}) + $signed({{6{i1_q[19]}}, i1_q}) - fb2;
        if (i1_sum > I1_MAX)      i1_sat = 20'h7FFFF;
        else if (i1_sum < I1_MIN) i1_sat = 20'h80000;
        else                      i1_sat = i1_sum[19:0];
        if (i2_sum > I2_MAX)      i2_sat = 24'h7FFFFF;
        else if (i2_sum < I2_MIN) i2_sat = 24'h800000;
        else                      i2_sat = i2_sum[23:0];
    end

    always_comb begin
        state_d = state_q;
        i1_d    = i1_q;
        i2_d    = i2_q;
        bit_d   = bit_q;
        count_d = count_q;
        cont_d  = cont_q;
`ifdef DSM2_DITHER_EN
        lfsr_d  = lfsr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    i1_d    = '0;
                    i2_d    = '0;
                    bit_d   = 1'b0;
                    count_d = burst_len;
                    cont_d  = (burst_len == '0);
`ifdef DSM2_DITHER_EN
                    lfsr_d  = 16'hACE1;
`endif
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (!cont_q && count_q == '0) begin
                    state_d = ST_DONE;
                end else if (mod_en) begin
                    i1_d  = i1_sat;
                    i2_d  = i2_sat;
                    bit_d = ~i2_sat[23];
                    if (!cont_q) count_d = count_q - 1'b1;
`ifdef DSM2_DITHER_EN
                    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
`endif
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // out shows the previous bit only while staying in RUN; any exit or entry blanks it.
    assign out_live = (state_q == ST_RUN) && (state_d == ST_RUN);

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_out
        assign out_d[gi] = out_live & bit_q & chan_mask[gi];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            i1_q    <= '0;
            i2_q    <= '0;
            bit_q   <= 1'b0;
            count_q <= '0;
            cont_q  <= 1'b0;
            out_q   <= '0;
`ifdef DSM2_DITHER_EN
            lfsr_q  <= 16'hACE1;
`endif
        end else begin
            state_q <= state_d;
            i1_q    <= i1_d;
            i2_q    <= i2_d;
            bit_q   <= bit_d;
            count_q <= count_d;
            cont_q  <= cont_d;
            out_q   <= out_d;
`ifdef DSM2_DITHER_EN
            lfsr_q  <= lfsr_d;
`endif
        end
    end

    assign out  = out_q;
    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);

endmodule

// File: doc/dsm2_stim_echip65.md
Name: dsm2_stim_echip65

Overview:
- Digital 2nd-order delta-sigma modulator that generates the 1-bit stimulus for the 12-filter CIC3 row, one bit per filter input pin.
- Replaces the analog modulator for on-chip digital self-test of the filter bank.
- Converts a programmable signed 16-bit DC code into a 1-bit density stream on the filter clock, with run/burst control and per-channel masking.

Parameters:
- NUM_CH, 12, number of 1-bit outputs (one per filter input).
- CNT_W, 16, width of the burst-length counter.

Ports:
- clk  input  1  common filter/modulator clock.
- reset  input  1  synchronous, active-high reset.
- mod_en  input  1  clock enable; the modulator advances only on cycles with mod_en=1.
- x_in  input  16  signed two's-complement input code, full scale ±32768; sampled on every advancing cycle.
- start  input  1  single-cycle pulse; begins a burst when idle.
- abort  input  1  single-cycle pulse; stops a burst immediately.
- burst_len  input  CNT_W  number of output bits per burst; 0 = continuous until abort.
- chan_mask  input  NUM_CH  per-channel output enable.
- out  output  NUM_CH  modulator bitstream to filter inputs, in[k] = out[k].
- busy  output  1  high while RUN.
- done  output  1  one-cycle pulse at normal burst completion.

Behaviour:
- Reset (clk edge with reset=1) sets every register to 0: out=0, busy=0, done=0, i1=0, i2=0, bit_q=0, count=0, state IDLE. Reset has priority over every other input and aborts a run in progress.
- FSM states:
  - IDLE: start=1 -> RUN. On entry, count loads burst_len and i1, i2, bit_q clear to 0.
  - RUN: abort=1 -> IDLE (no done pulse). Count expiry -> DONE.
  - DONE: lasts one cycle with done=1, then -> IDLE.
- start while in RUN or DONE is ignored. start and abort in the same IDLE cycle: start wins. abort in IDLE is a no-op.
- busy=1 exactly in RUN.
- Loop arithmetic, evaluated on RUN cycles with mod_en=1:
  - v = bit_q ? +32768 : -32768.
  - i1_n = i1 + sx(x_in) - v, with i1 20-bit signed.
  - i2_n = i2 + i1 - v, with i2 24-bit signed; this uses the old i1.
  - Both integrators saturate at their signed min/max and never wrap.
  - bit_q <= (i2_n >= 0).
- out = {NUM_CH{bit_q}} & chan_mask, registered. out is forced to 0 whenever state != RUN. Latency from the bit_q update to out is one clk.
- Counting:
  - burst_len != 0: count decrements on each advancing cycle. The advancing cycle that takes count from 1 to 0 is the last one; the FSM enters DONE on the next clk.
  - burst_len = 0: never decrements; run continues until abort.
- mod_en=0 in RUN: all loop state, count and out hold.
- A mid-burst change of x_in takes effect on the next advancing cycle. A change of chan_mask takes effect on the next clk.

Optional Feature:
- Macro DSM2_DITHER_EN.
- When defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 at reset and on RUN entry) advances on every advancing cycle. Its LSB, scaled to ±1 LSB, is added to i1_n before saturation, to break idle tones.
- When undefined: no LFSR and no dither; arithmetic exactly as in Behaviour.

Test Plan:
- Reset mid-burst: burst_len=100, start, then assert reset at cycle 20 -> next clk out=0, busy=0, done=0; subsequent start begins from cleared state.
- Zero input: x_in=0, chan_mask=12'hFFF, burst_len=1024, mod_en=1, start -> 1024 advancing cycles, ones count 512±2 on every bit; done pulses once on the cycle after the last bit; busy falls with it.
- DC +0.5FS: x_in=16384, burst_len=4096 -> ones density 0.75±0.002; out identical across all 12 bits.
- Mask and enable: chan_mask=12'h005, mod_en toggling 1/0 -> only out[0] and out[2] toggle, others stay 0; with mod_en=0, out and count hold; the burst takes exactly burst_len enabled cycles.
- Handshake: burst_len=0, start -> runs past 70000 cycles with no done; second start ignored; abort -> IDLE next clk, out=0, no done pulse; start and abort in the same IDLE cycle -> enters RUN.
- Saturation: x_in=-32768 for 2000 cycles -> i1/i2 clamp without sign flip, out stays predominantly 0 (ones density < 0.01), no wrap-induced burst of 1s.
